lsu_dmem_ctrl: RTL

Load/store unit between the RV32I core's MEM stage and the word-only data memory (256 x 32, asynchronous read, synchronous write on `MemRW`). It accepts one load/store request at a time over a valid/ready handshake and sign/zero-extends byte and halfword loads. Sub-word stores are implemented as read-modify-write. Misaligned or illegal accesses are flagged without touching memory.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu_dmem_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and RV32I
// memory-access funct3 codes.
package lsu_pkg;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE  = 3'd0;
  localparam lsu_state_t ST_LOAD  = 3'd1;
  localparam lsu_state_t ST_MERGE = 3'd2;
  localparam lsu_state_t ST_WRITE = 3'd3;
  localparam lsu_state_t ST_RESP  = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// and access legality checks for a little-endian 32-bit word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{addr_lo, 3'b000} +: 8];
  assign lane_h = word[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    load_ext = 32'h0;
    unique case (funct3)
      F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_ext = word;
      F3_BU:   load_ext = {24'h0, lane_b};
      F3_HU:   load_ext = {16'h0, lane_h};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    merged = word;
    unique case (funct3)
      F3_B:    merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  // Halfwords need addr[0]=0 and words need addr[1:0]=0; bytes never misalign.
  assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

  assign illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the MEM stage and a word-only data memory:
// one request at a time, sub-word stores done as read-modify-write.
module lsu_dmem_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_MemRW,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        is_idle;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [31:0] load_ext, merged;
  logic        misaligned, illegal, req_err;

  assign is_idle = (state_q == ST_IDLE);

  // In IDLE the checker looks at the live request; afterwards at the capture.
  assign al_funct3  = is_idle ? req_funct3     : funct3_q;
  assign al_addr_lo = is_idle ? req_addr[1:0]  : addr_q[1:0];

  lsu_align u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .load_ext  (load_ext),
    .merged    (merged),
    .misaligned(misaligned),
    .illegal   (illegal)
  );

  // Stores only define SB/SH/SW; funct3[2] set is illegal for a store.
  assign req_err = misaligned || illegal || (req_we && req_funct3[2]);

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = req_err;
          if (req_err) begin
            state_d = ST_RESP;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_funct3 == F3_W) begin
            merged_d = req_wdata;
            state_d  = ST_WRITE;
          end else begin
            state_d = ST_MERGE;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = load_ext;
        state_d = ST_RESP;
      end
      ST_MERGE: begin
        merged_d = merged;
        state_d  = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory strobes are pure state decodes so reset removes them immediately.
  assign req_ready  = is_idle;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_MemRW  = (state_q == ST_WRITE);
  assign mem_addr   = (state_q inside {ST_LOAD, ST_MERGE, ST_WRITE}) ?
                      {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = mem_MemRW ? merged_q : 32'h0;

endmodule
